spi_mem_arb: RTL and testbench
==============================

SPI_MEM_ARB -- requirements
Module: spi_mem_arb

Interface
REQ-001 The block SHALL have one clock and asynchronous, active-low reset; ports clk and rst_n, with rst_n low forcing reset immediately, independent of clk.
REQ-002 Parameters: none; address and data widths are fixed at 8 bits.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk: in, 1, rising-edge clock.
- rst_n: in, 1, async active-low reset.
- rx_data: in, 10, SPI frame; [9:8] command, [7:0] payload.
- rx_valid: in, 1, one-cycle strobe qualifying rx_data.
- tx_data: out, 8, read data returned to SPI.
- tx_valid: out, 1, one-cycle strobe qualifying tx_data.
- spi_ovf: out, 1, sticky SPI request-dropped flag.
- host_req: in, 1, host access request.
- host_we: in, 1, host access type; 1 = write.
- host_addr: in, 8, host address.
- host_wdata: in, 8, host write data.
- host_gnt: out, 1, one-cycle grant pulse.
- host_rdata: out, 8, host read data.
- host_rvalid: out, 1, one-cycle strobe qualifying host_rdata.
- mem_addr: out, 8, RAM address.
- mem_wdata: out, 8, RAM write data.
- mem_we: out, 1, RAM write strobe.
- mem_re: out, 1, RAM read strobe.
- mem_rdata: in, 8, RAM read data; valid the cycle after mem_re.

Function
REQ-004 On rx_valid, command 00 SHALL load wr_addr <= payload, and 10 SHALL load rd_addr <= payload; neither touches RAM.
REQ-005 On rx_valid, command 01 SHALL capture {write, wr_addr, payload} and command 11 SHALL capture {read, rd_addr}, each into a single SPI pending slot.
REQ-006 Any 00/10 arriving while the slot is full SHALL NOT alter the captured address.
REQ-007 After a served SPI write, wr_addr SHALL increment by 1; after a served SPI read, rd_addr SHALL increment by 1; both wrap 8'hFF -> 8'h00.
REQ-008 A 01/11 command arriving while the slot is full SHALL be dropped and SHALL set spi_ovf; spi_ovf clears only on reset.
REQ-009 The FSM SHALL have states IDLE, GNT_SPI, GNT_HOST and RD_WAIT.
REQ-010 IDLE: if exactly one of slot-full and host_req is active, go to that requester's GNT state.
REQ-011 IDLE: if both are active, grant the requester not granted last.
REQ-012 IDLE: if neither is active, stay in IDLE.
REQ-013 The last-granted bit SHALL update on every grant and SHALL reset to HOST, so SPI wins the first tie.
REQ-014 GNT_x SHALL last exactly one cycle.
REQ-015 In GNT_x, mem_addr and mem_wdata SHALL carry the granted request and exactly one of mem_we/mem_re SHALL be high.
REQ-016 GNT_HOST SHALL assert host_gnt in the same cycle.
REQ-017 GNT_SPI SHALL free the slot at the clock edge ending the state.
REQ-018 From GNT_x, a write SHALL return to IDLE and a read SHALL go to RD_WAIT.
REQ-019 RD_WAIT SHALL last one cycle; at its closing edge, mem_rdata is registered into tx_data (SPI) or host_rdata (host).
REQ-020 The matching tx_valid/host_rvalid SHALL pulse for one cycle after RD_WAIT, and the state SHALL return to IDLE.
REQ-021 mem_we and mem_re SHALL be decoded from registered state only and SHALL never be high together.
REQ-022 At most one RAM access SHALL be issued per GNT cycle.
REQ-023 Host SHALL hold host_req, host_we, host_addr and host_wdata stable until host_gnt; host_req still high the cycle after host_gnt is a new request.
REQ-024 SPI read latency: rx_valid in cycle N (uncontended) SHALL yield mem_re in N+2 and tx_valid in N+4.
REQ-025 SPI write latency: rx_valid in cycle N (uncontended) SHALL yield mem_we in N+2.
REQ-026 A new SPI command captured in the same cycle the slot is freed SHALL be accepted without setting spi_ovf.
REQ-027 Outside GNT states, mem_addr and mem_wdata SHALL hold their last values.

Reset
REQ-028 While rst_n is low: state = IDLE; wr_addr, rd_addr and the pending slot = 0; last-grant = HOST.
REQ-029 While rst_n is low, every output SHALL be 0, including spi_ovf.
REQ-030 Reset asserted mid-access (GNT or RD_WAIT) SHALL abort the access; no tx_valid/host_rvalid SHALL follow, and no partial strobe SHALL occur after rst_n rises.

Verification
REQ-031 The bench SHALL cover these scenarios:
- SPI write: rx 0x0_05, then 0x1_A5, then 0x2_05, then 0x3_xx -> mem_we at addr 05 with data A5; tx_data=A5 with tx_valid 4 cycles after the 0x3 frame.
- Auto-increment wrap: rx 0x0_FF, then two 0x1 writes -> RAM writes at FF then 00.
- Arbitration: slot full and host_req high in the same IDLE cycle after reset -> SPI granted first, host next; repeat the tie -> order alternates.
- Overflow: two 0x3 frames back-to-back while host holds the RAM -> second dropped, spi_ovf=1, exactly one tx_valid.
- Reset mid-read: rst_n low during RD_WAIT -> tx_valid never pulses; all outputs 0; next SPI read works normally.
- Host read: host_req with we=0, addr 10 -> host_gnt one cycle with mem_re; host_rvalid two cycles later carrying mem_rdata.

Source files
------------

// File: rtl/spi_mem_arb.sv
// Arbitrates a single-port RAM between an SPI command stream and a host port.
// SPI writes/reads go through auto-incrementing address pointers and one pending slot.
`timescale 1ns/1ps
module spi_mem_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       spi_ovf,
  input  logic       host_req,
  input  logic       host_we,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic       host_gnt,
  output logic [7:0] host_rdata,
  output logic       host_rvalid,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic       mem_re,
  input  logic [7:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT_SPI = 2'd1, GNT_HOST = 2'd2, RD_WAIT = 2'd3} state_e;

  state_e     state_q, state_d;
  logic [7:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic       slot_full_q, slot_full_d, slot_we_q, slot_we_d;
  logic [7:0] slot_addr_q, slot_addr_d, slot_data_q, slot_data_d;
  logic       ovf_q, ovf_d, last_spi_q, last_spi_d;
  logic       gnt_spi_q, gnt_spi_d, gnt_we_q, gnt_we_d;
  logic [7:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [7:0] tx_data_q, tx_data_d, host_rdata_q, host_rdata_d;
  logic       tx_valid_q, tx_valid_d, host_rvalid_q, host_rvalid_d;

  logic [1:0] cmd_s;
  logic [7:0] pay_s, wr_base_s, rd_base_s;
  logic       serve_spi_s, slot_avail_s;

  assign cmd_s        = rx_data[9:8];
  assign pay_s        = rx_data[7:0];
  assign serve_spi_s  = (state_q == GNT_SPI);
  // A capture in the serving cycle must already see the post-increment pointer.
  assign wr_base_s    = (serve_spi_s && gnt_we_q)  ? wr_addr_q + 8'd1 : wr_addr_q;
  assign rd_base_s    = (serve_spi_s && !gnt_we_q) ? rd_addr_q + 8'd1 : rd_addr_q;
  assign slot_avail_s = !slot_full_q || serve_spi_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (slot_full_q && host_req) begin
          state_d = last_spi_q ? GNT_HOST : GNT_SPI;
        end else if (slot_full_q) begin
          state_d = GNT_SPI;
        end else if (host_req) begin
          state_d = GNT_HOST;
        end else begin
          state_d = IDLE;
        end
      end
      GNT_SPI:  state_d = gnt_we_q ? IDLE : RD_WAIT;
      GNT_HOST: state_d = gnt_we_q ? IDLE : RD_WAIT;
      RD_WAIT:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    host_gnt = 1'b0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    case (state_q)
      GNT_SPI: begin
        mem_we = gnt_we_q;
        mem_re = !gnt_we_q;
      end
      GNT_HOST: begin
        host_gnt = 1'b1;
        mem_we   = gnt_we_q;
        mem_re   = !gnt_we_q;
      end
      default: begin
        host_gnt = 1'b0;
      end
    endcase
  end

  always_comb begin
    wr_addr_d     = wr_base_s;
    rd_addr_d     = rd_base_s;
    slot_full_d   = slot_full_q && !serve_spi_s;
    slot_we_d     = slot_we_q;
    slot_addr_d   = slot_addr_q;
    slot_data_d   = slot_data_q;
    ovf_d         = ovf_q;
    last_spi_d    = last_spi_q;
    gnt_spi_d     = gnt_spi_q;
    gnt_we_d      = gnt_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    tx_valid_d    = 1'b0;
    tx_data_d     = tx_data_q;
    host_rvalid_d = 1'b0;
    host_rdata_d  = host_rdata_q;

    if (rx_valid) begin
      case (cmd_s)
        2'b00: wr_addr_d = pay_s;
        2'b10: rd_addr_d = pay_s;
        2'b01, 2'b11: begin
          if (slot_avail_s) begin
            slot_full_d = 1'b1;
            slot_we_d   = (cmd_s == 2'b01);
            slot_addr_d = (cmd_s == 2'b01) ? wr_base_s : rd_base_s;
            slot_data_d = (cmd_s == 2'b01) ? pay_s : 8'h00;
          end else begin
            ovf_d = 1'b1;
          end
        end
        default: ovf_d = ovf_q;
      endcase
    end else begin
      ovf_d = ovf_q;
    end

    // Latch the winning request on entry to a grant state; it holds afterwards.
    if (state_q == IDLE && state_d == GNT_SPI) begin
      gnt_spi_d   = 1'b1;
      gnt_we_d    = slot_we_q;
      mem_addr_d  = slot_addr_q;
      mem_wdata_d = slot_data_q;
      last_spi_d  = 1'b1;
    end else if (state_q == IDLE && state_d == GNT_HOST) begin
      gnt_spi_d   = 1'b0;
      gnt_we_d    = host_we;
      mem_addr_d  = host_addr;
      mem_wdata_d = host_wdata;
      last_spi_d  = 1'b0;
    end else begin
      gnt_spi_d   = gnt_spi_q;
    end

    if (state_q == RD_WAIT && gnt_spi_q) begin
      tx_valid_d = 1'b1;
      tx_data_d  = mem_rdata;
    end else if (state_q == RD_WAIT) begin
      host_rvalid_d = 1'b1;
      host_rdata_d  = mem_rdata;
    end else begin
      tx_valid_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q     <= 8'h00;
      rd_addr_q     <= 8'h00;
      slot_full_q   <= 1'b0;
      slot_we_q     <= 1'b0;
      slot_addr_q   <= 8'h00;
      slot_data_q   <= 8'h00;
      ovf_q         <= 1'b0;
      last_spi_q    <= 1'b0;
      gnt_spi_q     <= 1'b0;
      gnt_we_q      <= 1'b0;
      mem_addr_q    <= 8'h00;
      mem_wdata_q   <= 8'h00;
      tx_data_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
      host_rdata_q  <= 8'h00;
      host_rvalid_q <= 1'b0;
    end else begin
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      slot_full_q   <= slot_full_d;
      slot_we_q     <= slot_we_d;
      slot_addr_q   <= slot_addr_d;
      slot_data_q   <= slot_data_d;
      ovf_q         <= ovf_d;
      last_spi_q    <= last_spi_d;
      gnt_spi_q     <= gnt_spi_d;
      gnt_we_q      <= gnt_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      host_rdata_q  <= host_rdata_d;
      host_rvalid_q <= host_rvalid_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign spi_ovf     = ovf_q;
  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_spi_mem_arb.sv
// Self-checking bench for spi_mem_arb: directed scenarios plus randomized
// uncontended traffic against a transaction-level pointer/RAM model.
`timescale 1ns/1ps
module tb_spi_mem_arb;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid, spi_ovf;
  logic       host_req, host_we;
  logic [7:0] host_addr, host_wdata;
  logic       host_gnt;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic [7:0] mem_addr, mem_wdata;
  logic       mem_we, mem_re;
  logic [7:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  // RAM device: unwritten locations return addr^C3.
  logic [7:0] ram [256];
  logic       ram_v [256] = '{default: 1'b0};
  // Reference model: expected RAM contents and SPI pointers.
  logic [7:0] sh [256];
  logic       sh_v [256] = '{default: 1'b0};
  logic [7:0] m_wr, m_rd;

  spi_mem_arb dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .spi_ovf(spi_ovf),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr]   <= mem_wdata;
      ram_v[mem_addr] <= 1'b1;
    end
    if (mem_re) mem_rdata <= ram_v[mem_addr] ? ram[mem_addr] : (mem_addr ^ 8'hC3);
  end

  function automatic logic [7:0] exp_rd(input logic [7:0] a);
    return sh_v[a] ? sh[a] : (a ^ 8'hC3);
  endfunction

  function automatic logic [37:0] outs();
    return {tx_data, tx_valid, spi_ovf, host_gnt, host_rdata, host_rvalid,
            mem_addr, mem_wdata, mem_we, mem_re};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spi_send(input logic [1:0] c, input logic [7:0] p);
    rx_data  = {c, p};
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 10'h000;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    m_wr  = 8'h00;
    m_rd  = 8'h00;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 10'h000;
    host_req = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;
    #2;
    n_cmp++; if (outs() !== 38'h0) begin n_err++; $display("FAIL reset_outs: got %h want 0", outs()); end
    repeat (3) tick();
    rst_n = 1'b1; m_wr = 8'h00; m_rd = 8'h00;
    tick(); tick();
    n_cmp++; if (outs() !== 38'h0) begin n_err++; $display("FAIL idle_outs: got %h want 0", outs()); end
  endtask

  task automatic test_spi_write();
    spi_send(2'b00, 8'h05); m_wr = 8'h05;
    spi_send(2'b01, 8'hA5);
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL wr_early: mem_we got %b want 0", mem_we); end
    tick();
    n_cmp++; if ({mem_we, mem_re, mem_addr, mem_wdata} !== {1'b1, 1'b0, m_wr, 8'hA5}) begin
      n_err++; $display("FAIL spi_wr: got %b%b %h %h want 10 %h a5", mem_we, mem_re, mem_addr, mem_wdata, m_wr); end
    sh[m_wr] = 8'hA5; sh_v[m_wr] = 1'b1; m_wr = m_wr + 8'd1;
    spi_send(2'b10, 8'h05); m_rd = 8'h05;
    spi_send(2'b11, 8'h00);
    tick();
    n_cmp++; if ({mem_we, mem_re, mem_addr} !== {1'b0, 1'b1, m_rd}) begin
      n_err++; $display("FAIL spi_rd_re: got %b%b %h want 01 %h", mem_we, mem_re, mem_addr, m_rd); end
    tick();
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL tx_early: got %b want 0", tx_valid); end
    tick();
    n_cmp++; if ({tx_valid, tx_data} !== {1'b1, 8'hA5}) begin
      n_err++; $display("FAIL spi_rd_tx: got %b %h want 1 a5", tx_valid, tx_data); end
    m_rd = m_rd + 8'd1;
    tick();
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL tx_pulse: got %b want 0", tx_valid); end
  endtask

  task automatic test_wrap();
    logic [7:0] d1, d2;
    d1 = 8'($urandom); d2 = 8'($urandom);
    spi_send(2'b00, 8'hFF); m_wr = 8'hFF;
    spi_send(2'b01, d1);
    tick();
    n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'hFF, d1}) begin
      n_err++; $display("FAIL wrap_ff: got %b %h %h want 1 ff %h", mem_we, mem_addr, mem_wdata, d1); end
    sh[m_wr] = d1; sh_v[m_wr] = 1'b1; m_wr = m_wr + 8'd1;
    spi_send(2'b01, d2);
    n_cmp++; if ({mem_we, spi_ovf} !== 2'b00) begin
      n_err++; $display("FAIL free_capture: got we=%b ovf=%b want 0 0", mem_we, spi_ovf); end
    tick();
    n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h00, d2}) begin
      n_err++; $display("FAIL wrap_00: got %b %h %h want 1 00 %h", mem_we, mem_addr, mem_wdata, d2); end
    sh[m_wr] = d2; sh_v[m_wr] = 1'b1; m_wr = m_wr + 8'd1;
    tick();
  endtask

  task automatic tie_case(input bit spi_first);
    logic [7:0] ds, ha, hd;
    ds = 8'($urandom); ha = 8'($urandom); hd = 8'($urandom);
    spi_send(2'b01, ds);
    host_req = 1'b1; host_we = 1'b1; host_addr = ha; host_wdata = hd;
    for (int k = 0; k < 2; k++) begin
      tick();
      if ((k == 0) == spi_first) begin
        n_cmp++; if ({host_gnt, mem_we, mem_addr, mem_wdata} !== {1'b0, 1'b1, m_wr, ds}) begin
          n_err++; $display("FAIL tie_spi%0d: got g=%b we=%b %h %h want 0 1 %h %h", k, host_gnt, mem_we, mem_addr, mem_wdata, m_wr, ds); end
        sh[m_wr] = ds; sh_v[m_wr] = 1'b1; m_wr = m_wr + 8'd1;
      end else begin
        n_cmp++; if ({host_gnt, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, ha, hd}) begin
          n_err++; $display("FAIL tie_host%0d: got g=%b we=%b %h %h want 1 1 %h %h", k, host_gnt, mem_we, mem_addr, mem_wdata, ha, hd); end
        host_req = 1'b0;
        sh[ha] = hd; sh_v[ha] = 1'b1;
      end
      if (k == 0) begin
        tick();
        n_cmp++; if ({host_gnt, mem_we, mem_re} !== 3'b000) begin
          n_err++; $display("FAIL tie_gap: got %b%b%b want 000", host_gnt, mem_we, mem_re); end
      end
    end
    tick();
  endtask

  task automatic test_arbitration();
    logic [7:0] d;
    apply_reset();
    tie_case(1'b1);
    d = 8'($urandom);
    spi_send(2'b01, d);
    tick();
    n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, m_wr, d}) begin
      n_err++; $display("FAIL solo_spi: got %b %h %h want 1 %h %h", mem_we, mem_addr, mem_wdata, m_wr, d); end
    sh[m_wr] = d; sh_v[m_wr] = 1'b1; m_wr = m_wr + 8'd1;
    tick();
    tie_case(1'b0);
  endtask

  task automatic test_overflow();
    logic [7:0] ra, ha, got;
    int ntx;
    apply_reset();
    ra = 8'($urandom); ha = 8'($urandom); ntx = 0; got = 8'h00;
    spi_send(2'b10, ra); m_rd = ra;
    host_req = 1'b1; host_we = 1'b0; host_addr = ha;
    tick();
    n_cmp++; if ({host_gnt, mem_re} !== 2'b11) begin n_err++; $display("FAIL ovf_hgnt: got %b%b want 11", host_gnt, mem_re); end
    host_req = 1'b0;
    rx_data = {2'b11, 8'h00}; rx_valid = 1'b1;
    tick();
    n_cmp++; if (spi_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b want 0", spi_ovf); end
    tick();
    rx_valid = 1'b0;
    n_cmp++; if ({spi_ovf, host_rvalid, host_rdata} !== {1'b1, 1'b1, exp_rd(ha)}) begin
      n_err++; $display("FAIL ovf_set: got ovf=%b rv=%b %h want 1 1 %h", spi_ovf, host_rvalid, host_rdata, exp_rd(ha)); end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx_valid === 1'b1) begin ntx++; got = tx_data; end
    end
    n_cmp++; if (ntx !== 1 || got !== exp_rd(m_rd)) begin
      n_err++; $display("FAIL ovf_tx: got count=%0d data=%h want 1 %h", ntx, got, exp_rd(m_rd)); end
    m_rd = m_rd + 8'd1;
    n_cmp++; if (spi_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", spi_ovf); end
  endtask

  task automatic test_reset_mid_read();
    int nbad;
    nbad = 0;
    spi_send(2'b10, 8'($urandom));
    spi_send(2'b11, 8'h00);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (outs() !== 38'h0) begin n_err++; $display("FAIL rst_mid_outs: got %h want 0", outs()); end
    repeat (2) tick();
    rst_n = 1'b1; m_wr = 8'h00; m_rd = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (tx_valid !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0) nbad++;
    end
    n_cmp++; if (nbad !== 0) begin n_err++; $display("FAIL rst_abort: got %0d strobe cycles want 0", nbad); end
    spi_send(2'b11, 8'h00);
    tick(); tick(); tick();
    n_cmp++; if ({tx_valid, tx_data} !== {1'b1, exp_rd(m_rd)}) begin
      n_err++; $display("FAIL rst_after_rd: got %b %h want 1 %h", tx_valid, tx_data, exp_rd(m_rd)); end
    m_rd = m_rd + 8'd1;
    tick();
  endtask

  task automatic test_host_read();
    logic [7:0] hd;
    hd = 8'($urandom);
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = hd;
    tick();
    n_cmp++; if ({host_gnt, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 8'h10, hd}) begin
      n_err++; $display("FAIL host_wr: got %b%b %h %h want 11 10 %h", host_gnt, mem_we, mem_addr, mem_wdata, hd); end
    host_req = 1'b0; sh[8'h10] = hd; sh_v[8'h10] = 1'b1;
    tick();
    host_req = 1'b1; host_we = 1'b0;
    tick();
    n_cmp++; if ({host_gnt, mem_we, mem_re, mem_addr} !== {1'b1, 1'b0, 1'b1, 8'h10}) begin
      n_err++; $display("FAIL host_rd_gnt: got %b%b%b %h want 101 10", host_gnt, mem_we, mem_re, mem_addr); end
    host_req = 1'b0;
    tick();
    n_cmp++; if ({host_gnt, host_rvalid} !== 2'b00) begin n_err++; $display("FAIL host_rd_gap: got %b%b want 00", host_gnt, host_rvalid); end
    tick();
    n_cmp++; if ({host_rvalid, host_rdata} !== {1'b1, hd}) begin
      n_err++; $display("FAIL host_rd_data: got %b %h want 1 %h", host_rvalid, host_rdata, hd); end
    tick();
    n_cmp++; if (host_rvalid !== 1'b0) begin n_err++; $display("FAIL host_rv_pulse: got %b want 0", host_rvalid); end
  endtask

  task automatic test_random();
    logic [7:0] a, d;
    int op;
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 5);
      a  = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
      d  = 8'($urandom);
      case (op)
        0: begin spi_send(2'b00, a); m_wr = a; tick(); end
        1: begin spi_send(2'b10, a); m_rd = a; tick(); end
        2: begin
          spi_send(2'b01, d); tick();
          n_cmp++; if ({mem_we, mem_re, mem_addr, mem_wdata} !== {2'b10, m_wr, d}) begin
            n_err++; $display("FAIL rnd_spi_wr%0d: got %b%b %h %h want 10 %h %h", it, mem_we, mem_re, mem_addr, mem_wdata, m_wr, d); end
          sh[m_wr] = d; sh_v[m_wr] = 1'b1; m_wr = m_wr + 8'd1; tick();
        end
        3: begin
          spi_send(2'b11, 8'h00); tick();
          n_cmp++; if ({mem_we, mem_re, mem_addr} !== {2'b01, m_rd}) begin
            n_err++; $display("FAIL rnd_spi_re%0d: got %b%b %h want 01 %h", it, mem_we, mem_re, mem_addr, m_rd); end
          tick(); tick();
          n_cmp++; if ({tx_valid, tx_data} !== {1'b1, exp_rd(m_rd)}) begin
            n_err++; $display("FAIL rnd_spi_tx%0d: got %b %h want 1 %h", it, tx_valid, tx_data, exp_rd(m_rd)); end
          m_rd = m_rd + 8'd1; tick();
        end
        4: begin
          host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d; tick();
          n_cmp++; if ({host_gnt, mem_we, mem_addr, mem_wdata} !== {2'b11, a, d}) begin
            n_err++; $display("FAIL rnd_host_wr%0d: got %b%b %h %h want 11 %h %h", it, host_gnt, mem_we, mem_addr, mem_wdata, a, d); end
          host_req = 1'b0; sh[a] = d; sh_v[a] = 1'b1; tick();
        end
        default: begin
          host_req = 1'b1; host_we = 1'b0; host_addr = a; tick();
          n_cmp++; if ({host_gnt, mem_re, mem_addr} !== {2'b11, a}) begin
            n_err++; $display("FAIL rnd_host_re%0d: got %b%b %h want 11 %h", it, host_gnt, mem_re, mem_addr, a); end
          host_req = 1'b0; tick(); tick();
          n_cmp++; if ({host_rvalid, host_rdata} !== {1'b1, exp_rd(a)}) begin
            n_err++; $display("FAIL rnd_host_rd%0d: got %b %h want 1 %h", it, host_rvalid, host_rdata, exp_rd(a)); end
          tick();
        end
      endcase
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_spi_write();
    test_wrap();
    test_arbitration();
    test_overflow();
    test_reset_mid_read();
    test_host_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
